// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, instruction fields,
// and the select/op codes driven onto the datapath muxes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_SH  = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_R     = 4'd6,
    ST_WB_I     = 4'd7,
    ST_MEM_ADDR = 4'd8,
    ST_MEM_RD   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_WB_MEM   = 4'd11,
    ST_BRANCH   = 4'd12,
    ST_JUMP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALU_SRC_A_PC   = 2'b00;
  localparam logic [1:0] ALU_SRC_A_REGA = 2'b01;
  localparam logic [1:0] ALU_SRC_A_REGB = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REGB  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_SHAMT = 2'b10;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b11;

  localparam logic IMM_SEXT     = 1'b0;
  localparam logic IMM_SEXT_SH2 = 1'b1;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_OPCODE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic isShiftFunct(input logic [5:0] f);
    return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
  endfunction

  function automatic logic isAluFunct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic and unsupported-instruction detection.
// memReady only matters in FETCH and the two memory-access states.
module mc_next_state
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       memReady,
  input  logic       idleDone,
  output state_t     nextState,
  output logic       illegal
);

  always_comb begin
    nextState = ST_FETCH;
    illegal   = 1'b0;
    case (state)
      ST_IDLE:  nextState = idleDone ? ST_FETCH : ST_IDLE;
      ST_FETCH: nextState = memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode == OP_RTYPE && isShiftFunct(funct)) begin
          nextState = ST_EXEC_SH;
        end else if (opcode == OP_RTYPE && isAluFunct(funct)) begin
          nextState = ST_EXEC_R;
        end else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) begin
          nextState = ST_EXEC_I;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          nextState = ST_MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          nextState = ST_BRANCH;
        end else if (opcode == OP_J) begin
          nextState = ST_JUMP;
        end else begin
          illegal = 1'b1;
        end
      end
      ST_EXEC_R:   nextState = ST_WB_R;
      ST_EXEC_SH:  nextState = ST_WB_R;
      ST_EXEC_I:   nextState = ST_WB_I;
      ST_MEM_ADDR: nextState = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   nextState = memReady ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR:   nextState = memReady ? ST_FETCH : ST_MEM_WR;
      // Writeback, branch, jump and any unused encoding all return to FETCH.
      default:     nextState = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle core: state register, post-reset IDLE hold
// and output decode. Only FETCH's pcWrite/irWrite look at memReady directly.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       immSel,
  output logic [1:0] aluOp,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSrc,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       illegal
);

  state_t     state;
  state_t     nextState;
  logic [3:0] idleCnt;
  logic       idleDone;

  // The zero flag is consumed by the datapath through pcWriteCond, not by the FSM.
  logic unusedZero;
  assign unusedZero = zero;

  assign idleDone = (idleCnt == 4'(RESET_PC_HOLD - 1));

  mc_next_state uNext (
    .state     (state),
    .opcode    (opcode),
    .funct     (funct),
    .memReady  (memReady),
    .idleDone  (idleDone),
    .nextState (nextState),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idleCnt <= 4'd0;
    end else begin
      state <= nextState;
      if (state == ST_IDLE && !idleDone) begin
        idleCnt <= idleCnt + 4'd1;
      end
    end
  end

  always_comb begin
    aluSrcA     = ALU_SRC_A_PC;
    aluSrcB     = ALU_SRC_B_REGB;
    immSel      = IMM_SEXT;
    aluOp       = ALUOP_ADD;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSrc       = PCSRC_ALU;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    case (state)
      ST_FETCH: begin
        memRead = 1'b1;
        aluSrcB = ALU_SRC_B_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      ST_DECODE: begin
        aluSrcB = ALU_SRC_B_IMM;
        immSel  = IMM_SEXT_SH2;
      end
      ST_EXEC_R: begin
        aluSrcA = ALU_SRC_A_REGA;
        aluOp   = ALUOP_FUNCT;
      end
      ST_EXEC_SH: begin
        aluSrcA = ALU_SRC_A_REGB;
        aluSrcB = ALU_SRC_B_SHAMT;
        aluOp   = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        aluSrcA = ALU_SRC_A_REGA;
        aluSrcB = ALU_SRC_B_IMM;
        aluOp   = ALUOP_OPCODE;
      end
      ST_WB_R: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      ST_WB_I: regWrite = 1'b1;
      ST_MEM_ADDR: begin
        aluSrcA = ALU_SRC_A_REGA;
        aluSrcB = ALU_SRC_B_IMM;
      end
      ST_MEM_RD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      ST_MEM_WR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      ST_WB_MEM: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      ST_BRANCH: begin
        aluSrcA     = ALU_SRC_A_REGA;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSrc       = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule
